// File: rtl/bitvec_pkg.sv
// Shared definitions for the vector-serialization path.
//   DEFAULT_WIDTH : default word width
//   state_t       : deserializer control states
//   bit_reverse   : reverses the low w bits of a vector (also used by the transmitter)
package bitvec_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_WIDTH     = 64;
  localparam int MAX_WB        = $clog2(MAX_WIDTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  function automatic logic [MAX_WIDTH-1:0] bit_reverse(input logic [MAX_WIDTH-1:0] v,
                                                       input int w);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++)
      if (i < w) r[MAX_WB'(i)] = v[MAX_WB'(w - 1 - i)];
    return r;
  endfunction
endpackage

// File: rtl/serial_word_deserializer_if.sv
// Serial-in / word-out bundle of the deserializer.
//   master : bit source and word consumer (drives bits, out_ready)
//   slave  : the deserializer (drives out_data, out_valid, busy, overrun)
interface serial_word_deserializer_if
  import bitvec_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             bit_in;
  logic             bit_valid;
  logic             frame_start;
  logic             msb_first;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;

  modport master (output bit_in, bit_valid, frame_start, msb_first, out_ready,
                  input  out_data, out_valid, busy, overrun);
  modport slave  (input  bit_in, bit_valid, frame_start, msb_first, out_ready,
                  output out_data, out_valid, busy, overrun);
endinterface

// File: rtl/vector_bit_reverse.sv
// Combinational bit reversal: o_vec[i] = i_vec[WIDTH-1-i].
//   i_vec : input vector
//   o_vec : reversed vector
module vector_bit_reverse
  import bitvec_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [WIDTH-1:0] o_vec
);
  for (genvar g = 0; g < WIDTH; g++) begin : g_rev
    assign o_vec[g] = i_vec[WIDTH-1-g];
  end
endmodule

// File: rtl/serial_word_deserializer.sv
// Reassembles a serial bit stream into WIDTH-bit words, MSB- or LSB-first per
// word, and hands them out through a one-entry valid/ready register.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of serial_word_deserializer_if (bits in, words out,
//              busy while a word is partial, overrun pulse on a dropped word)
module serial_word_deserializer
  import bitvec_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  serial_word_deserializer_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  state_t           r_state, w_state_n;
  logic [CW-1:0]    r_cnt, w_cnt_n;
  // Only WIDTH-1 history bits are needed; the last bit comes straight from bit_in.
  logic [WIDTH-2:0] r_sh, w_sh_n;
  logic             r_order, w_order_n;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_overrun;
  logic             w_done;
  logic [WIDTH-1:0] w_word_msb, w_word_rev, w_word;

  assign w_word_msb = {r_sh, bus.bit_in};

  vector_bit_reverse #(.WIDTH(WIDTH)) u_rev (
    .i_vec (w_word_msb),
    .o_vec (w_word_rev)
  );

  // A word can only complete in SHIFT, so the latched order is always the right one.
  assign w_word = r_order ? w_word_msb : w_word_rev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_order <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_sh    <= w_sh_n;
      r_order <= w_order_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_sh_n    = r_sh;
    w_order_n = r_order;
    w_done    = 1'b0;
    if (bus.bit_valid) begin
      w_sh_n = w_word_msb[WIDTH-2:0];
      if (r_state == IDLE || bus.frame_start) begin
        // bit 0 of a new word; frame_start here restarts the word on this bit
        w_order_n = bus.msb_first;
        w_cnt_n   = CW'(1);
        w_state_n = SHIFT;
      end else if (r_cnt == CW'(WIDTH - 1)) begin
        w_done    = 1'b1;
        w_cnt_n   = '0;
        w_state_n = IDLE;
      end else begin
        w_cnt_n = r_cnt + CW'(1);
      end
    end else if (bus.frame_start) begin
      w_cnt_n   = '0;
      w_state_n = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_done) begin
        // A slot being consumed this edge is free: no bubble between words.
        if (!r_out_valid || bus.out_ready) begin
          r_out_data  <= w_word;
          r_out_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = (r_state == SHIFT);
  assign bus.overrun   = r_overrun;
endmodule

// File: doc/serial_word_deserializer.md
# serial_word_deserializer

Receives a serial bit stream one bit per qualified clock and reassembles it into WIDTH-bit parallel words. Bit order is selectable per word: MSB-first or LSB-first. The internal bit-reversal stage maps LSB-first streams to natural bit order. The block is the receive end of the team's vector-serialization path and delivers completed words through a one-entry valid/ready output register.

## Interface
- `WIDTH`, default 8: word width in bits; legal range is 2 or more.
- `clk`  in  1: sole clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `bit_in`  in  1: serial data bit.
- `bit_valid`  in  1: `bit_in` is accepted on this edge.
- `frame_start`  in  1: resynchronization strobe; discards any partial word.
- `msb_first`  in  1: bit order, sampled only when bit 0 of a word is accepted.
  - 1: the first bit received lands in `out_data[WIDTH-1]`.
  - 0: the first bit received lands in `out_data[0]`.
- `out_data`  out  WIDTH: assembled word.
- `out_valid`  out  1: `out_data` holds an unconsumed word.
- `out_ready`  in  1: consumer accepts the word on an edge where `out_valid` is 1.
- `busy`  out  1: a partial word is in progress (state SHIFT).
- `overrun`  out  1: single-cycle pulse when a completed word is dropped.

## Operation
- **State machine:** IDLE and SHIFT, plus a bit counter `cnt` (0..WIDTH-1), a shift register `sh`, and a latched `order` bit.
- **IDLE:**
  - On `bit_valid`: `sh` shifts in `bit_in` at the LSB end, `order` latches `msb_first`, `cnt` becomes 1, and the state goes to SHIFT.
- **SHIFT:**
  - Each `bit_valid` shifts the bit in and increments `cnt`.
  - On the bit where `cnt == WIDTH-1`, the word completes, `cnt` wraps to 0, and the state returns to IDLE.
- **Word formation:**
  - `order == 1`: the word is `{sh[WIDTH-2:0], bit_in}`.
  - `order == 0`: the word is the bit-reverse of that value.
- **Completion:**
  - If the output register is empty, or is being consumed this edge (`out_valid && out_ready`): load `out_data` with the word and set `out_valid`. There is no bubble.
  - Otherwise: drop the word, leave `out_data` unchanged, and pulse `overrun` for one cycle.
- **Consumption:** `out_valid && out_ready` with no completion on the same edge clears `out_valid`. `out_data` holds its last value.
- **frame_start:**
  - Without `bit_valid`: `cnt` becomes 0 and the state goes to IDLE. Partial bits are discarded and no overrun is flagged.
  - With `bit_valid`: the current bit is taken as bit 0 of a new word. `order` re-latches, `cnt` becomes 1, and the state is SHIFT.
  - `frame_start` never affects the output register.
- **Ignored input:** `msb_first` changes mid-word have no effect.
- **WIDTH rule:** `cnt` is `$clog2(WIDTH)` bits wide.

## Timing
- **Reset values:** `out_data` = 0, `out_valid` = 0, `busy` = 0, `overrun` = 0. Internally `cnt` = 0, `sh` = 0, state = IDLE.
- **Mid-word reset:** any partial word and any held output are lost immediately, with no pulse.
- **Latency:** `out_valid` rises on the edge that accepts the final bit. It is visible in the cycle after that bit was presented.
- **Throughput:** the minimum word period is WIDTH cycles. Back-to-back words with `out_ready` held at 1 give continuous delivery.
- **Gaps:** gaps in `bit_valid` of any length are legal. The partial word is held indefinitely.
- **Output stability:** `out_data` is stable while `out_valid` = 1 and `out_ready` = 0.
- **Handshake:** `out_valid` never depends combinationally on `out_ready`.
- **busy:** is 1 exactly while the state is SHIFT.
- **overrun:** registered, asserted for the one cycle following the dropping edge.

## Structure
- **Shared package `bitvec_pkg`:**
  - the default width constant (8);
  - the state enum `{IDLE, SHIFT}`;
  - a `bit_reverse` function reused by the transmit side.
- **Sub-module:** a combinational `vector_bit_reverse #(WIDTH)` instance performs the LSB-first reorder. No other sub-modules.

## Test plan
- **MSB-first word:** `msb_first` = 1, bits 0,0,0,1,1,1,1,0 on consecutive cycles, `out_ready` = 1 → `out_valid` for one cycle with `out_data` = 0x1E.
- **LSB-first word:** the same stream with `msb_first` = 0 → `out_data` = 0x78. Toggling `msb_first` mid-word leaves the result at 0x78.
- **Back-to-back with gaps:** 0x1E then 0xA5 (MSB-first), `bit_valid` gapped randomly, `out_ready` = 1 → two words delivered in order and `busy` drops between them.
- **Overrun:** `out_ready` = 0 and two words streamed → the first word (0x1E) is held, `overrun` pulses once after the second completes, and `out_data` stays 0x1E. Raising `out_ready` then clears `out_valid`.
- **Resynchronization:**
  - After 3 bits, `frame_start` without `bit_valid`, then 8 bits of 0x3C → `out_data` = 0x3C.
  - `frame_start` coincident with the first bit → same result, `out_data` = 0x3C.
- **Reset mid-word:** assert `rst` after 5 bits with a word held → all outputs 0 at once. The next 8 bits produce a correct word.
